// File: rtl/safety_core_periph_bridge.sv
// ============================================================================
// Module   : safety_core_periph_bridge
// Brief    : Core data port (req/gnt/rvalid) to register-interface bridge for
//            the core-local peripheral window, with timeout abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

package safety_core_periph_bridge_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module safety_core_periph_bridge
    import safety_core_periph_bridge_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE_ADDR = 32'h0020_0000,
    parameter logic [31:0] PERIPH_SIZE      = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES   = 64,
    parameter logic [31:0] ERR_RDATA        = 32'hBADC_AB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [32:0]      c_WIN_LO = {1'b0, PERIPH_BASE_ADDR};
    // 33-bit upper bound so a window ending exactly at 2^32 does not wrap
    localparam logic [32:0]      c_WIN_HI = {1'b0, PERIPH_BASE_ADDR} + {1'b0, PERIPH_SIZE};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESP    = 2'd2,
        S_ERRRESP = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [31:0]      addr_q,    addr_d;
    logic             we_q,      we_d;
    logic [3:0]       be_q,      be_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             timeout_q, timeout_d;

    logic             w_in_win;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_in_win  = ({1'b0, data_addr_i} >= c_WIN_LO) && ({1'b0, data_addr_i} < c_WIN_HI);
    assign w_cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        data_gnt_o    = 1'b0;
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_gnt_o = data_req_i;
                cnt_d      = '0;
                if (data_req_i) begin
                    addr_d  = data_addr_i;
                    we_d    = data_we_i;
                    be_d    = data_be_i;
                    wdata_d = data_wdata_i;
                    state_d = w_in_win ? S_ACCESS : S_ERRRESP;
                end
            end
            S_ACCESS: begin
                // Ready has priority over a timeout hit in the same cycle
                if (reg_rsp_i.ready) begin
                    rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
                    err_d   = reg_rsp_i.error;
                    state_d = S_RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = S_ERRRESP;
                    end
                end
            end
            S_RESP: begin
                data_rvalid_o = 1'b1;
                data_err_o    = err_q;
                data_rdata_o  = (err_q && !we_q) ? ERR_RDATA : rdata_q;
                cnt_d         = '0;
                state_d       = S_IDLE;
            end
            S_ERRRESP: begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                data_rdata_o  = we_q ? 32'h0 : ERR_RDATA;
                cnt_d         = '0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = {addr_q[31:2], 2'b00};
        reg_req_o.write = we_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = be_q;
        reg_req_o.valid = (state_q == S_ACCESS);
    end

    assign timeout_o = timeout_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

`default_nettype wire
